inst_d: RTL
===========

# inst_d

Instruction decode stage of the 5-stage pipeline, sitting directly downstream of instruction fetch. It holds the IF/ID pipeline register and a 32x32 register file with a write-back port. It decodes instruction fields and detects load-use hazards. The `hazard` output drives the fetch stage's `hazard` input so the PC and IF/ID hold together for one bubble cycle.

## Interface
Parameters: none (fixed 32-bit datapath, 32 registers).

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `instruction`  in  32  fetched instruction from fetch stage
- `pc4`  in  32  PC+4 of fetched instruction
- `flush`  in  1  taken branch/jump resolved in EX; kill the instruction in IF/ID
- `ex_mem_read`  in  1  instruction currently in ID/EX is a load
- `ex_rt`  in  5  destination register of that load
- `wb_en`  in  1  write-back enable
- `wb_addr`  in  5  write-back register
- `wb_data`  in  32  write-back data
- `hazard`  out  1  load-use stall request (to fetch stage and ID/EX bubble insertion)
- `id_valid`  out  1  IF/ID holds a live instruction
- `id_opcode`  out  6  instr[31:26]
- `id_rs`, `id_rt`, `id_rd`  out  5 each  instr[25:21], [20:16], [15:11]
- `id_rs_data`, `id_rt_data`  out  32  register operands
- `id_imm`  out  32  extended immediate
- `id_pc4`  out  32  PC+4 carried with the instruction

## Operation
- **IF/ID register** (`ir`, `ir_pc4`, `ir_valid`), updated on each posedge, priority highest first:
  - `rst`: `ir`=0, `ir_pc4`=0, `ir_valid`=0.
  - `flush`: `ir`=0, `ir_pc4`=0, `ir_valid`=0. Flush wins over hazard.
  - `hazard`: hold all three.
  - otherwise: `ir`=`instruction`, `ir_pc4`=`pc4`, `ir_valid`=1.
- **Field outputs** are combinational from `ir`. `id_valid`=`ir_valid`, `id_pc4`=`ir_pc4`.
- **Immediate:**
  - opcode 001100 (andi) or 001101 (ori): zero-extend ir[15:0].
  - all other opcodes: sign-extend ir[15:0].
- **Register file**, 32 x 32:
  - `rst` clears all entries to 0.
  - Write on posedge when `wb_en` && `wb_addr`!=0. r0 is never written and always reads 0.
  - Reads are combinational with write-through bypass. If `wb_en` && `wb_addr`!=0 && `wb_addr`==read address, output `wb_data`; otherwise the stored value.
- **Hazard detection** (combinational):
  - `uses_rt` = 1 when opcode is 000000 (R-type), 101011 (sw), 000100 (beq) or 000101 (bne).
  - `hazard` = `ir_valid` && `ex_mem_read` && `ex_rt`!=0 && (`ex_rt`==`id_rs` || (`uses_rt` && `ex_rt`==`id_rt`)).
  - `hazard` is 0 during reset, and 0 whenever `ir_valid`=0, including after a flush.

## Timing
- Latency: an instruction presented at posedge N (hazard=0, flush=0) appears on the `id_*` outputs after N, valid for one cycle unless stalled.
- Stall: while `hazard`=1, IF/ID holds and the fetch PC holds. The downstream ID/EX register must insert a bubble.
  - `hazard` deasserts once the load leaves ID/EX (`ex_mem_read` drops). This normally gives exactly 1 stall cycle.
- Write-back in the same cycle as a read of the same register returns the new data (bypass). The stored value updates at the following posedge.
- Reset values of outputs: `id_valid`=0, `id_opcode`/`id_rs`/`id_rt`/`id_rd`=0, `id_imm`=0, `id_pc4`=0, `id_rs_data`/`id_rt_data`=0, `hazard`=0.
- Reset asserted mid-stall clears the IF/ID register and register file at that posedge. No hazard the next cycle.
- Simultaneous `flush` and `hazard`: flush applies, IF/ID invalidated, `hazard` falls to 0 the next cycle.

## Test plan
- **Reset:** assert `rst` 2 cycles with `wb_en`=1, `wb_addr`=5 -> all outputs 0; after release, r5 reads 0.
- **Write-back/bypass:**
  - `wb_en`=1, `wb_addr`=8, `wb_data`=0xDEADBEEF; IF/ID holds add r3,r8,r9 (0x01091820) -> `id_rs_data`=0xDEADBEEF in the same cycle and after.
  - `wb_addr`=0 -> r0 stays 0.
- **Decode:**
  - 0x2128FFFC (addi r8,r9,-4) -> `id_rs`=9, `id_rt`=8, `id_imm`=0xFFFFFFFC.
  - 0x3528FFFC (ori) -> `id_imm`=0x0000FFFC.
- **Load-use stall:**
  - `ex_mem_read`=1, `ex_rt`=8; IF/ID holds add r3,r8,r9 -> `hazard`=1, IF/ID unchanged at the next posedge despite a new `instruction`.
  - Drop `ex_mem_read` -> `hazard`=0, next instruction captured.
- **Hazard qualification:**
  - `ex_rt`=8 vs addi r8,r9,-4 (rt=8 not read) -> `hazard`=0.
  - `ex_rt`=0 with rs=0 -> `hazard`=0.
- **Flush:**
  - `flush`=1 together with `hazard`=1 -> next cycle `id_valid`=0, `ir`=0, `hazard`=0.
  - Following cycle captures the new `instruction` with `id_valid`=1.

Source files
------------

// File: rtl/inst_d.sv
// Instruction decode stage: IF/ID register, 32x32 register file, field decode, load-use detect.
// Latency: instruction captured at posedge appears on id_* outputs right after it; reads are combinational.
// Backpressure: hazard holds IF/ID (and the fetch PC) for one bubble; flush overrides hazard.
module inst_d (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [31:0] pc4,
    input  logic        flush,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        hazard,
    output logic        id_valid,
    output logic [5:0]  id_opcode,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [31:0] id_rs_data,
    output logic [31:0] id_rt_data,
    output logic [31:0] id_imm,
    output logic [31:0] id_pc4
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [31:0] ir;
    logic [31:0] ir_pc4;
    logic        ir_valid;
    logic [31:0] regs [32];
    logic        wb_we;
    logic        uses_rt;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ir       <= '0;
            ir_pc4   <= '0;
            ir_valid <= 1'b0;
        end else if (!hazard) begin
            ir       <= instruction;
            ir_pc4   <= pc4;
            ir_valid <= 1'b1;
        end
    end

    assign wb_we = wb_en && (wb_addr != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_we) begin
            regs[wb_addr] <= wb_data;
        end
    end

    assign id_valid  = ir_valid;
    assign id_pc4    = ir_pc4;
    assign id_opcode = ir[31:26];
    assign id_rs     = ir[25:21];
    assign id_rt     = ir[20:16];
    assign id_rd     = ir[15:11];

    // Logical immediates are zero-extended; everything else (arith, loads/stores, branches) sign-extends.
    always_comb begin
        id_imm = {{16{ir[15]}}, ir[15:0]};
        if (id_opcode == OP_ANDI || id_opcode == OP_ORI)
            id_imm = {16'h0000, ir[15:0]};
    end

    // Write-through bypass so a write-back landing this cycle is seen without waiting for the edge.
    always_comb begin
        id_rs_data = '0;
        id_rt_data = '0;
        if (id_rs != 5'd0)
            id_rs_data = (wb_we && wb_addr == id_rs) ? wb_data : regs[id_rs];
        if (id_rt != 5'd0)
            id_rt_data = (wb_we && wb_addr == id_rt) ? wb_data : regs[id_rt];
    end

    always_comb begin
        uses_rt = (id_opcode == OP_RTYPE) || (id_opcode == OP_SW) ||
                  (id_opcode == OP_BEQ)   || (id_opcode == OP_BNE);
        hazard  = !rst && ir_valid && ex_mem_read && (ex_rt != 5'd0) &&
                  ((ex_rt == id_rs) || (uses_rt && ex_rt == id_rt));
    end

endmodule
